// File: rtl/line_fill_unit_pkg.sv
// Shared types and default geometry for the line fill unit and its request FIFO.
package line_fill_unit_pkg;

    localparam int unsigned LFU_ADDR_W    = 32;
    localparam int unsigned LFU_WORD_W    = 32;
    localparam int unsigned LFU_LINEITEMS = 16;
    localparam int unsigned LFU_WAYS      = 2;
    localparam int unsigned LFU_QDEPTH    = 4;
    localparam int unsigned LFU_OFFBITS   = $clog2(LFU_LINEITEMS * LFU_WORD_W / 8);
    localparam int unsigned LFU_WAYBITS   = $clog2(LFU_WAYS);
    localparam int unsigned LFU_LINE_W    = LFU_ADDR_W - LFU_OFFBITS;

    typedef logic bool_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BEATS,
        DELIVER
    } fill_state_t;

    typedef struct packed {
        logic [LFU_LINE_W-1:0]  line_addr;
        logic [LFU_WAYBITS-1:0] way;
    } fill_req_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/line_fill_unit_fill_req_fifo.sv
// Pending miss request queue with a parallel line-address lookup across valid entries.
module fill_req_fifo
    import line_fill_unit_pkg::*;
#(
    parameter int unsigned QDEPTH = LFU_QDEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  bool_t                 push,
    input  fill_req_t             push_data,
    input  bool_t                 pop,
    input  bool_t                 flush,
    input  logic [LFU_LINE_W-1:0] match_line,
    output fill_req_t             head,
    output bool_t                 full,
    output bool_t                 empty,
    output bool_t                 match
);

    localparam int unsigned PW = $clog2(QDEPTH);

    fill_req_t     mem_q [QDEPTH];
    logic [PW:0]   wr_ptr_q;
    logic [PW:0]   rd_ptr_q;
    logic [PW:0]   count;
    logic [PW-1:0] offs [QDEPTH];

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = count[PW];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[PW-1:0]];

    // An entry is live when its distance from the read pointer is below the fill count.
    always_comb begin
        match = 1'b0;
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            offs[i] = PW'(i) - rd_ptr_q[PW-1:0];
            if (({1'b0, offs[i]} < count) && (mem_q[i].line_addr == match_line)) begin
                match = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (flush) begin
                rd_ptr_q <= wr_ptr_q;
            end else if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/line_fill_unit.sv
// Cache miss handler: queues line requests, fetches lines beat by beat, hands them back for fill.
module line_fill_unit
    import line_fill_unit_pkg::*;
#(
    parameter int unsigned ADDR_W    = LFU_ADDR_W,
    parameter int unsigned WORD_W    = LFU_WORD_W,
    parameter int unsigned LINEITEMS = LFU_LINEITEMS,
    parameter int unsigned WAYS      = LFU_WAYS,
    parameter int unsigned QDEPTH    = LFU_QDEPTH,
    localparam int unsigned OFFBITS  = $clog2(LINEITEMS * WORD_W / 8),
    localparam int unsigned WAYBITS  = $clog2(WAYS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [WAYBITS-1:0]          req_way,
    input  logic                        flush,
    output logic                        mem_req,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic                        mem_ack,
    input  logic                        mem_rvalid,
    input  logic [WORD_W-1:0]           mem_rdata,
    output logic                        fill_valid,
    input  logic                        fill_ready,
    output logic [ADDR_W-1:0]           fill_addr,
    output logic [WAYBITS-1:0]          fill_way,
    output logic [LINEITEMS*WORD_W-1:0] fill_data,
    output logic [15:0]                 fills,
    output logic [15:0]                 merges
);

    localparam int unsigned LINE_W = ADDR_W - OFFBITS;
    localparam int unsigned BEAT_W = $clog2(LINEITEMS);

    fill_state_t                 state_q, state_d;
    logic [BEAT_W-1:0]           beat_cnt_q, beat_cnt_d;
    logic [WAYBITS-1:0]          cur_way_q, cur_way_d;
    logic                        mem_req_d;
    logic [ADDR_W-1:0]           mem_addr_d;
    logic                        fill_valid_d;
    logic [ADDR_W-1:0]           fill_addr_d;
    logic [WAYBITS-1:0]          fill_way_d;
    logic [LINEITEMS*WORD_W-1:0] fill_data_d;
    logic [15:0]                 fills_d;
    logic [15:0]                 merges_d;

    fill_req_t         push_entry;
    fill_req_t         head;
    bool_t             fifo_full;
    bool_t             fifo_empty;
    bool_t             fifo_match;
    bool_t             accept;
    bool_t             dup;
    bool_t             push;
    bool_t             pop;
    logic [LINE_W-1:0] req_line;
    logic [LINE_W-1:0] flight_line;

    assign req_line    = req_addr[ADDR_W-1:OFFBITS];
    assign flight_line = mem_addr[ADDR_W-1:OFFBITS];
    assign req_ready   = !fifo_full && !flush;
    assign accept      = req_valid && req_ready;
    // mem_addr holds the in-flight line from pop until the line is handed back.
    assign dup         = fifo_match || ((state_q != IDLE) && (flight_line == req_line));
    assign push        = accept && !dup;
    assign pop         = (state_q == IDLE) && !fifo_empty;
    assign push_entry  = '{line_addr: req_line, way: req_way};

    fill_req_fifo #(
        .QDEPTH(QDEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .match_line(req_line),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .match     (fifo_match)
    );

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        cur_way_d    = cur_way_q;
        mem_req_d    = mem_req;
        mem_addr_d   = mem_addr;
        fill_valid_d = fill_valid;
        fill_addr_d  = fill_addr;
        fill_way_d   = fill_way;
        fill_data_d  = fill_data;
        fills_d      = fills;
        merges_d     = (accept && dup) ? sat_inc(merges) : merges;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {head.line_addr, OFFBITS'(0)};
                    cur_way_d  = head.way;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d    = BEATS;
                    mem_req_d  = 1'b0;
                    beat_cnt_d = '0;
                end
            end
            BEATS: begin
                if (mem_rvalid) begin
                    fill_data_d[beat_cnt_q*WORD_W +: WORD_W] = mem_rdata;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == BEAT_W'(LINEITEMS - 1)) begin
                        state_d      = DELIVER;
                        fill_valid_d = 1'b1;
                        fill_addr_d  = mem_addr;
                        fill_way_d   = cur_way_q;
                    end
                end
            end
            DELIVER: begin
                if (fill_ready) begin
                    state_d      = IDLE;
                    fill_valid_d = 1'b0;
                    fills_d      = sat_inc(fills);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            cur_way_q  <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            fill_valid <= 1'b0;
            fill_addr  <= '0;
            fill_way   <= '0;
            fill_data  <= '0;
            fills      <= '0;
            merges     <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            cur_way_q  <= cur_way_d;
            mem_req    <= mem_req_d;
            mem_addr   <= mem_addr_d;
            fill_valid <= fill_valid_d;
            fill_addr  <= fill_addr_d;
            fill_way   <= fill_way_d;
            fill_data  <= fill_data_d;
            fills      <= fills_d;
            merges     <= merges_d;
        end
    end

endmodule

// File: tb/tb_line_fill_unit.sv
// Scoreboard bench for line_fill_unit with a behavioural memory responder.
module tb_line_fill_unit;

    logic         clock;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic [0:0]   req_way;
    logic         flush;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic         fill_valid;
    logic         fill_ready;
    logic [31:0]  fill_addr;
    logic [0:0]   fill_way;
    logic [511:0] fill_data;
    logic [15:0]  fills;
    logic [15:0]  merges;

    typedef struct {
        logic [31:0]  addr;
        logic         way;
        logic [511:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   fills_seen = 0;
    int   exp_fills = 0;
    int   exp_merges = 0;
    bit   a0_mode = 0;
    int   ack_delay = 1;
    bit   ack_hold = 0;
    int   served = 0;
    int   beats_sent = 0;
    bit   resp_busy = 0;

    line_fill_unit u_dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_way   (req_way),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .fill_valid(fill_valid),
        .fill_ready(fill_ready),
        .fill_addr (fill_addr),
        .fill_way  (fill_way),
        .fill_data (fill_data),
        .fills     (fills),
        .merges    (merges)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] beat_word(input logic [31:0] base, input int k);
        if (a0_mode) return 32'hA0 + 32'(k);
        return {base[23:0], 8'(k)};
    endfunction

    function automatic logic [511:0] line_of(input logic [31:0] base);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = beat_word(base, k);
        return l;
    endfunction

    // Memory model: ack after ack_delay cycles (or once released), then 16 beats back to back.
    initial begin
        logic [31:0] cap;
        mem_ack = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clock); #1;
            if (mem_req === 1'b1 && reset === 1'b0) begin
                resp_busy = 1;
                beats_sent = 0;
                cap = mem_addr;
                for (int i = 0; i < ack_delay; i++) begin @(posedge clock); #1; end
                while (ack_hold) begin @(posedge clock); #1; end
                mem_ack = 1'b1;
                @(posedge clock); #1;
                mem_ack = 1'b0;
                served++;
                for (int k = 0; k < 16; k++) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = beat_word(cap, k);
                    beats_sent = k + 1;
                    @(posedge clock); #1;
                end
                mem_rvalid = 1'b0;
                resp_busy = 0;
            end
        end
    end

    // Fill monitor: every consumed line is popped from the scoreboard and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (fill_valid === 1'b1 && fill_ready === 1'b1 && reset === 1'b0) begin
                fills_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_fill: got addr=%h way=%0d, required no fill", fill_addr, fill_way);
                end else begin
                    e = exp_q.pop_front();
                    if (fill_addr !== e.addr || fill_way !== e.way || fill_data !== e.data) begin
                        errors++;
                        $display("FAIL fill_line: got addr=%h way=%0d data=%h, required addr=%h way=%0d data=%h",
                                 fill_addr, fill_way, fill_data, e.addr, e.way, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    // Called at posedge+1; presents one request for one edge and reports whether it was ready.
    task automatic send_req(input logic [31:0] addr, input logic way, output bit acc);
        req_addr = addr;
        req_way = way;
        req_valid = 1'b1;
        @(negedge clock);
        acc = req_ready;
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_fills(input int target);
        int n = 0;
        while (fills_seen < target && n < 2000) begin tick(); n++; end
        checks++;
        if (fills_seen < target) begin
            errors++;
            $display("FAIL fill_timeout: got %0d fills, required %0d", fills_seen, target);
        end
    endtask

    task automatic test_single_fill();
        bit acc;
        a0_mode = 1;
        ack_delay = 3;
        exp_q.push_back('{32'h0000_1200, 1'b1, line_of(32'h0000_1200)});
        send_req(32'h0000_1234, 1'b1, acc);
        @(negedge clock);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL latency_early: got mem_req=%b, required 0", mem_req);
        end
        @(negedge clock);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1200) begin
            errors++;
            $display("FAIL latency_req: got mem_req=%b mem_addr=%h, required 1 00001200", mem_req, mem_addr);
        end
        tick();
        wait_fills(fills_seen + 1);
        exp_fills++;
        checks++;
        if (fills !== 16'(exp_fills) || merges !== 16'(exp_merges)) begin
            errors++;
            $display("FAIL single_counts: got fills=%0d merges=%0d, required %0d %0d", fills, merges, exp_fills, exp_merges);
        end
        a0_mode = 0;
        ack_delay = 1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_fills = 0;
        exp_merges = 0;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", req_ready); end
        checks++;
        if (mem_req !== 1'b0 || fill_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: got mem_req=%b fill_valid=%b, required 0 0", mem_req, fill_valid);
        end
        checks++;
        if (mem_addr !== '0 || fill_addr !== '0 || fill_way !== '0) begin
            errors++;
            $display("FAIL reset_addr: got mem_addr=%h fill_addr=%h fill_way=%0d, required 0 0 0", mem_addr, fill_addr, fill_way);
        end
        checks++;
        if (fill_data !== '0) begin errors++; $display("FAIL reset_data: got %h, required 0", fill_data); end
        checks++;
        if (fills !== 16'd0 || merges !== 16'd0) begin
            errors++; $display("FAIL reset_counts: got fills=%0d merges=%0d, required 0 0", fills, merges);
        end
        tick();
    endtask

    task automatic test_merge();
        bit acc;
        int served0 = served;
        exp_q.push_back('{32'h0000_1200, 1'b0, line_of(32'h0000_1200)});
        send_req(32'h0000_1200, 1'b0, acc);
        send_req(32'h0000_1230, 1'b0, acc);
        exp_merges++;
        wait_fills(fills_seen + 1);
        exp_fills++;
        repeat (30) tick();
        checks++;
        if (merges !== 16'(exp_merges) || fills !== 16'(exp_fills)) begin
            errors++;
            $display("FAIL merge_counts: got merges=%0d fills=%0d, required %0d %0d", merges, fills, exp_merges, exp_fills);
        end
        checks++;
        if (served !== served0 + 1) begin
            errors++; $display("FAIL merge_memreqs: got %0d memory requests, required 1", served - served0);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int base_seen = fills_seen;
        ack_hold = 1;
        for (int i = 0; i < 6; i++) begin
            send_req(32'(i * 32'h40), 1'(i), acc);
            if (i < 5) begin
                exp_q.push_back('{32'(i * 32'h40), 1'(i), line_of(32'(i * 32'h40))});
            end
            checks++;
            if (acc !== (i < 5)) begin
                errors++; $display("FAIL full_ready_%0d: got req_ready=%b, required %b", i, acc, (i < 5));
            end
        end
        @(negedge clock);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL full_inflight: got mem_req=%b mem_addr=%h, required 1 00000000", mem_req, mem_addr);
        end
        tick();
        ack_hold = 0;
        wait_fills(base_seen + 5);
        exp_fills += 5;
        checks++;
        if (fills !== 16'(exp_fills)) begin
            errors++; $display("FAIL full_fills: got %0d, required %0d", fills, exp_fills);
        end
    endtask

    task automatic test_backpressure();
        bit acc;
        int n = 0;
        int base_seen = fills_seen;
        fill_ready = 1'b0;
        exp_q.push_back('{32'h0000_3000, 1'b1, line_of(32'h0000_3000)});
        send_req(32'h0000_3000, 1'b1, acc);
        while (fill_valid !== 1'b1 && n < 300) begin tick(); n++; end
        checks++;
        if (fill_valid !== 1'b1) begin errors++; $display("FAIL bp_arrive: got fill_valid=%b, required 1", fill_valid); end
        exp_q.push_back('{32'h0000_3040, 1'b0, line_of(32'h0000_3040)});
        send_req(32'h0000_3040, 1'b0, acc);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            checks++;
            if (fill_valid !== 1'b1 || fill_addr !== 32'h0000_3000 || fill_data !== line_of(32'h0000_3000)) begin
                errors++;
                $display("FAIL bp_stable_%0d: got valid=%b addr=%h, required 1 00003000 with line data", c, fill_valid, fill_addr);
            end
            checks++;
            if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_memreq_%0d: got %b, required 0", c, mem_req); end
        end
        tick();
        fill_ready = 1'b1;
        wait_fills(base_seen + 2);
        exp_fills += 2;
        checks++;
        if (fills !== 16'(exp_fills)) begin errors++; $display("FAIL bp_fills: got %0d, required %0d", fills, exp_fills); end
    endtask

    task automatic test_reset_midfill();
        bit acc;
        int n = 0;
        send_req(32'h0000_4000, 1'b0, acc);
        while (!(resp_busy && beats_sent >= 6) && n < 200) begin tick(); n++; end
        checks++;
        if (beats_sent < 6) begin errors++; $display("FAIL rst_mid_beats: got %0d beats, required 6", beats_sent); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_fills = 0;
        exp_merges = 0;
        n = 0;
        while (resp_busy && n < 100) begin
            @(negedge clock);
            checks++;
            if (fill_valid !== 1'b0 || mem_req !== 1'b0) begin
                errors++; $display("FAIL rst_mid_ignore: got fill_valid=%b mem_req=%b, required 0 0", fill_valid, mem_req);
            end
            tick();
            n++;
        end
        tick();
        exp_q.push_back('{32'h0000_2000, 1'b1, line_of(32'h0000_2000)});
        send_req(32'h0000_2000, 1'b1, acc);
        wait_fills(fills_seen + 1);
        exp_fills++;
        checks++;
        if (fills !== 16'(exp_fills)) begin errors++; $display("FAIL rst_mid_fills: got %0d, required %0d", fills, exp_fills); end
    endtask

    task automatic test_flush();
        bit acc;
        int served0 = served;
        int base_seen = fills_seen;
        ack_hold = 1;
        exp_q.push_back('{32'h0000_5000, 1'b0, line_of(32'h0000_5000)});
        send_req(32'h0000_5000, 1'b0, acc);
        send_req(32'h0000_5040, 1'b1, acc);
        send_req(32'h0000_5080, 1'b0, acc);
        send_req(32'h0000_50C0, 1'b1, acc);
        flush = 1'b1;
        req_valid = 1'b1;
        req_addr = 32'h0000_6000;
        req_way = 1'b0;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b, required 0", req_ready); end
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready: got %b, required 1", req_ready); end
        tick();
        ack_hold = 0;
        wait_fills(base_seen + 1);
        exp_fills++;
        repeat (60) tick();
        checks++;
        if (fills !== 16'(exp_fills) || served !== served0 + 1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_result: got fills=%0d memreqs=%0d mem_req=%b, required %0d 1 0",
                     fills, served - served0, mem_req, exp_fills);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        req_way = '0;
        flush = 1'b0;
        fill_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        test_single_fill();
        test_reset();
        test_merge();
        test_back_to_back();
        test_backpressure();
        test_reset_midfill();
        test_flush();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d lines outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
